// File: rtl/wavetable_pkg.sv
// Shared types and defaults for the wavetable reader: FSM state encoding,
// default bus widths and the fractional-width helper.
package wavetable_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int TABLE_AW_DEF = 10;
    localparam int DATA_W_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH0,
        ST_FETCH1,
        ST_CAP,
        ST_INTERP
    } state_e;

    // Phase bits below the table index are the interpolation fraction.
    function automatic int frac_w(input int addr_w, input int table_aw);
        return addr_w - table_aw;
    endfunction

endpackage

// File: rtl/wavetable_reader_lerp.sv
// wt_lerp: combinational linear interpolation s0 + ((s1-s0)*frac >>> FRAC_W).
// Only compiled when WAVETABLE_INTERP_EN is defined, the only build that uses it.
`ifdef WAVETABLE_INTERP_EN
module wt_lerp #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 6
) (
    input  logic signed [DATA_W-1:0] s0_i,
    input  logic signed [DATA_W-1:0] s1_i,
    input  logic        [FRAC_W-1:0] frac_i,
    output logic signed [DATA_W-1:0] result_o
);

    localparam int PW = DATA_W + FRAC_W + 2;

    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   prod;
    logic signed [DATA_W:0] step;

    assign diff = $signed({s1_i[DATA_W-1], s1_i}) - $signed({s0_i[DATA_W-1], s0_i});
    assign prod = $signed({{(FRAC_W+1){diff[DATA_W]}}, diff})
                * $signed({{(DATA_W+2){1'b0}}, frac_i});

    // Arithmetic shift floors toward -inf, so the result always lies between s0 and s1.
    assign step     = (DATA_W+1)'(prod >>> FRAC_W);
    assign result_o = DATA_W'($signed({s0_i[DATA_W-1], s0_i}) + step);

endmodule
`endif

// File: rtl/wavetable_reader.sv
// Phase word -> wavetable ROM fetch -> (optionally interpolated) signed sample.
// WAVETABLE_INTERP_EN selects 2-tap linear interpolation; otherwise nearest-lower lookup.
module wavetable_reader
    import wavetable_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int TABLE_AW = TABLE_AW_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                i_clk5MHz,
    input  logic                i_rst,
    input  logic [ADDR_W-1:0]   i_phase,
    input  logic                i_valid,
    output logic                o_ready,
    output logic [TABLE_AW-1:0] o_rom_addr,
    input  logic [DATA_W-1:0]   i_rom_data,
    output logic [DATA_W-1:0]   o_sample,
    output logic                o_valid
);

    localparam int FRAC_W = frac_w(ADDR_W, TABLE_AW);

    state_e              state_q;
    logic [TABLE_AW-1:0] rom_addr_q;
    logic [DATA_W-1:0]   sample_q;
    logic                valid_q;

    assign o_ready    = (state_q == ST_IDLE);
    assign o_rom_addr = rom_addr_q;
    assign o_sample   = sample_q;
    assign o_valid    = valid_q;

`ifdef WAVETABLE_INTERP_EN
    logic        [FRAC_W-1:0] frac_q;
    logic signed [DATA_W-1:0] s0_q;
    logic signed [DATA_W-1:0] s1_q;
    logic signed [DATA_W-1:0] lerp_result;

    wt_lerp #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_lerp (
        .s0_i     (s0_q),
        .s1_i     (s1_q),
        .frac_i   (frac_q),
        .result_o (lerp_result)
    );

    // NOTE: reset is synchronous and checked first, so it overrides an accept in the same cycle.
    always_ff @(posedge i_clk5MHz) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            frac_q     <= '0;
            s0_q       <= '0;
            s1_q       <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        rom_addr_q <= i_phase[ADDR_W-1:FRAC_W];
                        frac_q     <= i_phase[FRAC_W-1:0];
                        state_q    <= ST_FETCH0;
                    end
                end
                ST_FETCH0: begin
                    // Top entry wraps to index 0 so the table behaves as one period.
                    rom_addr_q <= rom_addr_q + TABLE_AW'(1);
                    state_q    <= ST_FETCH1;
                end
                ST_FETCH1: begin
                    s0_q    <= i_rom_data;
                    state_q <= ST_CAP;
                end
                ST_CAP: begin
                    s1_q    <= i_rom_data;
                    state_q <= ST_INTERP;
                end
                ST_INTERP: begin
                    sample_q <= lerp_result;
                    valid_q  <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^i_phase[FRAC_W-1:0];

    // NOTE: reset is synchronous and checked first, so it overrides an accept in the same cycle.
    always_ff @(posedge i_clk5MHz) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        rom_addr_q <= i_phase[ADDR_W-1:FRAC_W];
                        state_q    <= ST_FETCH0;
                    end
                end
                ST_FETCH0: state_q <= ST_FETCH1;
                ST_FETCH1: begin
                    sample_q <= i_rom_data;
                    valid_q  <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_wavetable_reader.sv
// Self-checking bench for wavetable_reader: cycle-level reference model plus
// directed vectors; adapts to WAVETABLE_INTERP_EN the same way as the design.
module tb_wavetable_reader;

`ifdef WAVETABLE_INTERP_EN
    localparam int LAT    = 5;
    localparam bit INTERP = 1'b1;
    localparam logic [15:0] E_MID  = 16'd150;
    localparam logic [15:0] E_NEG  = 16'(-500);
    localparam logic [15:0] E_WRAP = 16'd63;
`else
    localparam int LAT    = 3;
    localparam bit INTERP = 1'b0;
    localparam logic [15:0] E_MID  = 16'd100;
    localparam logic [15:0] E_NEG  = 16'(-1000);
    localparam logic [15:0] E_WRAP = 16'd0;
`endif

    logic        clk;
    logic        i_rst;
    logic [15:0] i_phase;
    logic        i_valid;
    logic        o_ready;
    logic [9:0]  o_rom_addr;
    logic [15:0] i_rom_data;
    logic [15:0] o_sample;
    logic        o_valid;

    logic signed [15:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    wavetable_reader dut (
        .i_clk5MHz  (clk),
        .i_rst      (i_rst),
        .i_phase    (i_phase),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (i_rom_data),
        .o_sample   (o_sample),
        .o_valid    (o_valid)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    // Synchronous ROM with one-cycle read latency.
    always @(posedge clk) i_rom_data <= mem[o_rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] expect_val(input logic [15:0] ph);
        int idx;
        int fr;
        int s0;
        int s1;
        int d;
        int q;
        idx = int'(ph[15:6]);
        fr  = int'(ph[5:0]);
        s0  = int'(mem[idx]);
        s1  = int'(mem[(idx + 1) % 1024]);
        d   = (s1 - s0) * fr;
        if (d >= 0) q = d / 64;
        else        q = -((-d + 63) / 64);
        return INTERP ? 16'(s0 + q) : 16'(s0);
    endfunction

    // Reference model: compare outputs against the model every cycle, then advance it
    // using the inputs that the next rising edge will sample.
    bit          m_live = 1'b0;
    int          m_busy = 0;
    logic        m_valid;
    logic [15:0] m_sample;
    logic [9:0]  m_addr;
    logic [15:0] m_pend;
    logic [9:0]  m_pend_idx;

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("model_ready",    32'(o_ready),    32'(m_busy == 0));
                check("model_valid",    32'(o_valid),    32'(m_valid));
                check("model_sample",   32'(o_sample),   32'(m_sample));
                check("model_rom_addr", 32'(o_rom_addr), 32'(m_addr));
            end
            if (i_rst) begin
                m_live   = 1'b1;
                m_busy   = 0;
                m_valid  = 1'b0;
                m_sample = 16'd0;
                m_addr   = 10'd0;
            end else if (m_live) begin
                m_valid = 1'b0;
                if (m_busy > 0) begin
                    if (INTERP && m_busy == LAT - 1) m_addr = m_pend_idx + 10'd1;
                    m_busy--;
                    if (m_busy == 0) begin
                        m_valid  = 1'b1;
                        m_sample = m_pend;
                    end
                end else if (i_valid) begin
                    m_busy     = LAT - 1;
                    m_pend_idx = i_phase[15:6];
                    m_addr     = i_phase[15:6];
                    m_pend     = expect_val(i_phase);
                end
            end
        end
    end

    task automatic directed(input string nm, input logic [15:0] ph, input logic [15:0] exp_sample);
        logic [9:0] idx;
        logic [9:0] idx2;
        idx  = ph[15:6];
        idx2 = INTERP ? idx + 10'd1 : idx;
        @(posedge clk); #1;
        i_phase = ph;
        i_valid = 1'b1;
        @(negedge clk);
        check({nm, "_ready_c0"}, 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        check({nm, "_addr_c1"}, 32'(o_rom_addr), 32'(idx));
        check({nm, "_ready_c1"}, 32'(o_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_addr_c2"}, 32'(o_rom_addr), 32'(idx2));
        repeat (LAT - 2) @(posedge clk);
        @(negedge clk);
        check({nm, "_valid"},  32'(o_valid),  32'd1);
        check({nm, "_sample"}, 32'(o_sample), 32'(exp_sample));
        @(posedge clk);
        @(negedge clk);
        check({nm, "_valid_off"},  32'(o_valid),  32'd0);
        check({nm, "_sample_hold"}, 32'(o_sample), 32'(exp_sample));
    endtask

    initial begin
        #(200 * 20000);
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int strobes;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_phase = 16'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 50 - 25000);
        mem[1]    = 16'sd100;
        mem[2]    = 16'sd200;
        mem[5]    = -16'sd1000;
        mem[6]    = 16'sd1000;
        mem[1023] = 16'sd0;
        mem[0]    = 16'sd64;

        // Two reset cycles.
        @(posedge clk);
        @(negedge clk);
        check("rst_valid",    32'(o_valid),    32'd0);
        check("rst_sample",   32'(o_sample),   32'd0);
        check("rst_rom_addr", 32'(o_rom_addr), 32'd0);
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 32'(o_ready), 32'd1);

        directed("int",  16'h0040, 16'd100);
        directed("mid",  16'h0060, E_MID);
        directed("neg",  16'h0150, E_NEG);
        directed("wrap", 16'hFFFF, E_WRAP);
        repeat (2) @(posedge clk);

        // Back-to-back requests: words arriving while busy are dropped.
        strobes = 0;
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_phase = 16'h1234;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("busy_ready", 32'(o_ready), 32'((c % LAT) == 0));
            if (o_valid) strobes++;
            @(posedge clk); #1;
            i_phase = i_phase + 16'd1;
        end
        i_valid = 1'b0;
        check("busy_strobes", 32'(strobes), 32'(11 / LAT));
        repeat (LAT + 2) @(posedge clk);

        // Reset in the middle of a fetch discards the pending result.
        @(posedge clk); #1;
        i_phase = 16'h0040;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(o_ready),  32'd1);
        check("midrst_sample", 32'(o_sample), 32'd0);
        strobes = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            if (o_valid) strobes++;
        end
        check("midrst_no_valid", 32'(strobes), 32'd0);
        directed("after_rst", 16'h0060, E_MID);

        // Reset coinciding with a valid word: the word is not taken.
        @(posedge clk); #1;
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_phase = 16'h0040;
        @(posedge clk); #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        strobes = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            if (o_valid) strobes++;
        end
        check("rst_vs_valid", 32'(strobes), 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
